conv_config_sequencer: RTL and testbench

CONV_CONFIG_SEQUENCER -- requirements
Module: conv_config_sequencer

---
 rtl/conv_config_sequencer.sv | 169 ++++++++++++++++
 tb/tb_conv_config_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_config_sequencer.sv
// Shadow config register file streamed to the conv datapath over a valid/ready link.
// Optional CONFIG_CHECKSUM_EN adds cfg_checksum: XOR of the bytes sent in the current LOAD.
module conv_config_sequencer #(
  parameter int CONFIG_ADDR_WIDTH = 8,
  parameter int CONFIG_DATA_WIDTH = 8,
  parameter int NUM_REGS          = 34
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       host_wr_en,
  input  logic [CONFIG_ADDR_WIDTH-1:0]               host_wr_adr,
  input  logic [CONFIG_DATA_WIDTH-1:0]               host_wr_data,
  output logic                                       host_wr_err,
  input  logic                                       start,
  input  logic                                       stop,
  output logic [CONFIG_ADDR_WIDTH+CONFIG_DATA_WIDTH-1:0] config_data,
  output logic                                       config_vld,
  input  logic                                       config_rdy,
  output logic                                       run_en,
  output logic                                       busy,
`ifdef CONFIG_CHECKSUM_EN
  output logic [CONFIG_DATA_WIDTH-1:0]               cfg_checksum,
`endif
  output logic                                       done
);

  localparam int AW = CONFIG_ADDR_WIDTH;
  localparam int DW = CONFIG_DATA_WIDTH;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW+DW-1:0] config_data_q, config_data_d;
  logic             config_vld_q, config_vld_d;
  logic             run_en_q, run_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             host_wr_err_q, host_wr_err_d;
`ifdef CONFIG_CHECKSUM_EN
  logic [DW-1:0]    checksum_q, checksum_d;
`endif

  logic [DW-1:0]    shadow_q [NUM_REGS];
  logic             wr_ok;
  logic             xfer;
  logic [AW-1:0]    rd_idx;
  logic [DW-1:0]    rd_data;

  assign wr_ok = host_wr_en && (state_q == IDLE) && (host_wr_adr <= LAST_IDX);
  assign xfer  = config_vld_q && config_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) shadow_q[r] <= '0;
    end else if (wr_ok) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (host_wr_adr == AW'(r)) shadow_q[r] <= host_wr_data;
      end
    end
  end

  // Address of the word to present next: index 0 on start, idx+1 while loading.
  assign rd_idx = (state_q == LOAD) ? idx_q + 1'b1 : '0;

  // A write landing on the same edge as start is forwarded so index 0 is never stale.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rd_idx == AW'(r)) rd_data = shadow_q[r];
    end
    if (wr_ok && (host_wr_adr == rd_idx)) rd_data = host_wr_data;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    config_data_d = config_data_q;
    config_vld_d  = config_vld_q;
    run_en_d      = run_en_q;
    done_d        = 1'b0;
    host_wr_err_d = host_wr_en && !wr_ok;
`ifdef CONFIG_CHECKSUM_EN
    checksum_d    = checksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = LOAD;
          idx_d         = '0;
          config_vld_d  = 1'b1;
          config_data_d = {rd_idx, rd_data};
`ifdef CONFIG_CHECKSUM_EN
          checksum_d    = '0;
`endif
        end
      end
      LOAD: begin
        if (xfer) begin
`ifdef CONFIG_CHECKSUM_EN
          checksum_d = checksum_q ^ config_data_q[DW-1:0];
`endif
          if (idx_q == LAST_IDX) begin
            state_d      = RUN;
            config_vld_d = 1'b0;
            run_en_d     = 1'b1;
            done_d       = 1'b1;
          end else begin
            idx_d         = rd_idx;
            config_data_d = {rd_idx, rd_data};
          end
        end
      end
      RUN: begin
        // stop has priority; start is never looked at here
        if (stop) begin
          state_d  = IDLE;
          run_en_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        config_vld_d = 1'b0;
        run_en_d     = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      config_data_q <= '0;
      config_vld_q  <= 1'b0;
      run_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      host_wr_err_q <= 1'b0;
`ifdef CONFIG_CHECKSUM_EN
      checksum_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      config_data_q <= config_data_d;
      config_vld_q  <= config_vld_d;
      run_en_q      <= run_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      host_wr_err_q <= host_wr_err_d;
`ifdef CONFIG_CHECKSUM_EN
      checksum_q    <= checksum_d;
`endif
    end
  end

  assign config_data = config_data_q;
  assign config_vld  = config_vld_q;
  assign run_en      = run_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign host_wr_err = host_wr_err_q;
`ifdef CONFIG_CHECKSUM_EN
  assign cfg_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_conv_config_sequencer.sv
// Randomized bench for conv_config_sequencer against a shadow-array / transfer-order model.
// Build with CONFIG_CHECKSUM_EN defined to also check cfg_checksum.
module tb_conv_config_sequencer;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NR = 34;
  localparam int CW = AW + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_wr_en = 1'b0;
  logic [AW-1:0] host_wr_adr = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic          host_wr_err;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] config_data;
  logic          config_vld;
  logic          config_rdy = 1'b0;
  logic          run_en;
  logic          busy;
  logic          done;
`ifdef CONFIG_CHECKSUM_EN
  logic [DW-1:0] cfg_checksum;
`endif

  always #5 clk = ~clk;

  conv_config_sequencer #(
    .CONFIG_ADDR_WIDTH(AW),
    .CONFIG_DATA_WIDTH(DW),
    .NUM_REGS(NR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .host_wr_en(host_wr_en),
    .host_wr_adr(host_wr_adr),
    .host_wr_data(host_wr_data),
    .host_wr_err(host_wr_err),
    .start(start),
    .stop(stop),
    .config_data(config_data),
    .config_vld(config_vld),
    .config_rdy(config_rdy),
    .run_en(run_en),
    .busy(busy),
`ifdef CONFIG_CHECKSUM_EN
    .cfg_checksum(cfg_checksum),
`endif
    .done(done)
  );

  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] shadow_m [NR];
  bit            in_idle = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_m(input int idx);
    logic [CW-1:0] w;
    w = {AW'(idx), shadow_m[idx]};
    return 32'(w);
  endfunction

  function automatic logic [DW-1:0] xor_all_m();
    logic [DW-1:0] x;
    x = '0;
    for (int i = 0; i < NR; i++) x ^= shadow_m[i];
    return x;
  endfunction

  // Called at a negedge; one write cycle, error sampled at the following negedge.
  task automatic host_write(input int a, input logic [DW-1:0] d);
    bit exp_err;
    exp_err = !in_idle || (a >= NR);
    host_wr_en   = 1'b1;
    host_wr_adr  = AW'(a);
    host_wr_data = d;
    @(negedge clk);
    host_wr_en = 1'b0;
    check("wr_err", 32'(host_wr_err), 32'(exp_err));
    if (!exp_err) shadow_m[a] = d;
    $display("wr adr=%0d data=0x%0h err=%0b", a, d, host_wr_err);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_idle = 1'b0;
    check("busy_load", 32'(busy), 32'd1);
    check("run_en_load", 32'(run_en), 32'd0);
`ifdef CONFIG_CHECKSUM_EN
    check("cksum_clr", 32'(cfg_checksum), 32'd0);
`endif
  endtask

  task automatic do_stop(input bit with_start);
    stop  = 1'b1;
    start = with_start;
    @(negedge clk);
    stop  = 1'b0;
    start = 1'b0;
    in_idle = 1'b1;
    check("run_en_stop", 32'(run_en), 32'd0);
    check("busy_stop", 32'(busy), 32'd0);
    check("vld_stop", 32'(config_vld), 32'd0);
    @(negedge clk);
    check("vld_idle", 32'(config_vld), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // mode 0: rdy held high, 1: rdy 1,0,1,0..., 2: random rdy plus stray start/stop pulses
  task automatic run_load(input int mode, input int budget);
    int            idx;
    int            cyc;
    bit            rdy;
    bit            prev_stall;
    logic [CW-1:0] prev;
    idx = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev = '0;
    while (idx < NR && cyc < budget) begin
      check("vld_load", 32'(config_vld), 32'd1);
      check("done_early", 32'(done), 32'd0);
      if (prev_stall) check("hold", 32'(config_data), 32'(prev));
      check("xfer_data", 32'(config_data), word_m(idx));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      config_rdy = rdy;
      if (mode == 2) begin
        start = ($urandom_range(0, 4) == 0);
        stop  = ($urandom_range(0, 4) == 0);
      end
      prev = config_data;
      prev_stall = !rdy;
      if (rdy) begin
        $display("xfer idx=%0d data=0x%0h", idx, config_data);
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    config_rdy = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    check("xfer_count", 32'(idx), 32'(NR));
    if (mode == 0) check("sustained", 32'(cyc), 32'(NR));
    check("done_pulse", 32'(done), 32'd1);
    check("run_en_on", 32'(run_en), 32'd1);
    check("vld_after", 32'(config_vld), 32'd0);
    check("busy_run", 32'(busy), 32'd1);
`ifdef CONFIG_CHECKSUM_EN
    check("cksum", 32'(cfg_checksum), 32'(xor_all_m()));
`endif
    @(negedge clk);
    check("done_once", 32'(done), 32'd0);
    check("run_en_hold", 32'(run_en), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) shadow_m[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vld", 32'(config_vld), 32'd0);
    check("rst_run_en", 32'(run_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(host_wr_err), 32'd0);
    check("rst_data", 32'(config_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // stop in IDLE is ignored
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_idle", 32'(busy), 32'd0);

    // Directed pattern i+0x10, then out-of-range write
    for (int i = 0; i < NR; i++) host_write(i, DW'(i + 16));
    host_write(NR, 8'hEE);
    @(negedge clk);
    check("err_once", 32'(host_wr_err), 32'd0);

    do_start();
    run_load(0, 200);

    // In RUN: lone start ignored, write rejected
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_run", 32'(run_en), 32'd1);
    check("vld_in_run", 32'(config_vld), 32'd0);
    host_write(3, 8'h55);

    // start+stop together in RUN: stop wins
    do_stop(1'b1);

    // Re-stream same contents with rdy toggling; rejected write while LOAD is stalled
    do_start();
    host_write(5, 8'hAA);
    @(negedge clk);
    check("err_once_load", 32'(host_wr_err), 32'd0);
    check("hold_stall", 32'(config_data), word_m(0));
    run_load(1, 200);
`ifdef CONFIG_CHECKSUM_EN
    do_stop(1'b0);
    check("cksum_held", 32'(cfg_checksum), 32'(xor_all_m()));
`else
    do_stop(1'b0);
`endif

    // Async reset after the 10th transfer
    do_start();
    config_rdy = 1'b1;
    repeat (10) @(negedge clk);
    check("pre_rst_data", 32'(config_data), word_m(10));
    #2 rst_n = 1'b0;
    #1;
    check("async_vld", 32'(config_vld), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_data", 32'(config_data), 32'd0);
    for (int i = 0; i < NR; i++) shadow_m[i] = '0;
    in_idle = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_xfer_after_rst", 32'(config_vld), 32'd0);
      check("idle_after_rst", 32'(busy), 32'd0);
    end
    config_rdy = 1'b0;

    // Randomized rounds; partial writes also confirm reset cleared the shadow array
    for (int round = 0; round < 4; round++) begin
      for (int k = 0; k < 12; k++) host_write(int'($urandom_range(0, 40)), DW'($urandom));
      do_start();
      run_load(2, 400);
      do_stop($urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
